data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// MEM-stage to data-memory bus: request fields in, completion/stall out.
// Handshake: MemReqM is held with its fields while StallM=1. The request completes in the cycle MemReadyM=1, when RD and MisalignM are valid.
interface data_mem_responder_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        MemUnsignedM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] RD;
    logic        MemReadyM;
    logic        MisalignM;
    logic        StallM;

    modport master (
        output MemReqM, MemWriteM, MemSizeM, MemUnsignedM, ALUResultM, WriteDataM,
        input  RD, MemReadyM, MisalignM, StallM
    );

    modport slave (
        input  MemReqM, MemWriteM, MemSizeM, MemUnsignedM, ALUResultM, WriteDataM,
        output RD, MemReadyM, MisalignM, StallM
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: a word RAM with byte/half lanes,
// accessed after a fixed number of wait states.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output logic [1:0]            debug_state
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          unsigned_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req_misaligned;
    logic          do_access;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_data;

    // Only the bits that select a word and lane matter; the rest wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ALUResultM[31:AW+2];

    assign debug_state = state;
    assign do_access   = (state == WAIT) && (cnt == '0);
    assign idx         = addr_q[AW+1:2];
    assign lane        = addr_q[1:0];
    assign bus.StallM  = ((state == IDLE) && bus.MemReqM) || (state == WAIT);

    always_comb begin
        req_misaligned = 1'b0;
        case (bus.MemSizeM)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = bus.ALUResultM[0];
            default: req_misaligned = |bus.ALUResultM[1:0];
        endcase
    end

    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    always_comb begin
        rword     = mem[idx];
        rbyte     = rword[{lane, 3'b000} +: 8];
        rhalf     = lane[1] ? rword[31:16] : rword[15:0];
        load_data = rword;
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   load_data = unsigned_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_data = rword;
        endcase
    end

    // RAM is not reset; the reset term blocks a write on an edge that coincides with reset.
    always_ff @(posedge clk) begin
        if (!reset && do_access && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= 2'b00;
            write_q       <= 1'b0;
            unsigned_q    <= 1'b0;
            bus.RD        <= 32'h0;
            bus.MemReadyM <= 1'b0;
            bus.MisalignM <= 1'b0;
        end else begin
            bus.MemReadyM <= 1'b0;
            bus.MisalignM <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MemReqM) begin
                        addr_q     <= bus.ALUResultM[AW+1:0];
                        wdata_q    <= bus.WriteDataM;
                        size_q     <= bus.MemSizeM;
                        write_q    <= bus.MemWriteM;
                        unsigned_q <= bus.MemUnsignedM;
                        if (req_misaligned) begin
                            state         <= DONE;
                            bus.RD        <= 32'h0;
                            bus.MemReadyM <= 1'b1;
                            bus.MisalignM <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state         <= DONE;
                        bus.RD        <= write_q ? 32'h0 : load_data;
                        bus.MemReadyM <= 1'b1;
                    end
                end
                // The request still on the bus belongs to the completing instruction.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder with a byte-level
// reference memory and an expected-response queue.
module tb_data_mem_responder;
    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;
    localparam int MEMB        = DEPTH_WORDS * 4;

    logic       clk;
    logic       reset;
    logic [1:0] debug_state;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .debug_state (debug_state)
    );

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  ref_mem [MEMB];
    logic        at_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, size in bytes, plain arithmetic extension.
    function automatic logic [32:0] model_access(input logic w, input logic [1:0] sz, input logic u,
                                                 input logic [31:0] a, input logic [31:0] d);
        int          n;
        int          base;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if ((a % n) != 0) return {1'b1, 32'h0};
        base = int'(a % MEMB);
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return {1'b0, v};
    endfunction

    // Monitor: every completion pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.MemReadyM === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'h1, 32'h0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("rd", bus.RD, e[31:0]);
                    check("misalign", {31'h0, bus.MisalignM}, {31'h0, e[32]});
                end
            end else if (bus.MisalignM !== 1'b0) begin
                check("misalign_idle", {31'h0, bus.MisalignM}, 32'h0);
            end
        end
    end

    task automatic idle(input int n);
        bus.MemReqM = 1'b0;
        at_done     = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        logic [32:0] e;
        int          stalls;
        int          exp_stall;
        logic        seen;
        bus.MemReqM      = 1'b1;
        bus.MemWriteM    = w;
        bus.MemSizeM     = sz;
        bus.MemUnsignedM = u;
        bus.ALUResultM   = a;
        bus.WriteDataM   = d;
        e = model_access(w, sz, u, a, d);
        exp_q.push_back(e);
        exp_stall = e[32] ? 1 : LATENCY + 1;
        stalls    = 0;
        seen      = 1'b0;
        if (at_done) begin
            @(negedge clk);
            #1;
        end else begin
            #1;
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            if (bus.MemReadyM === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.StallM === 1'b1) stalls++;
                @(negedge clk);
                #1;
            end
        end
        at_done = seen;
        check("completion_seen", {31'h0, seen}, 32'h1);
        check("stall_cycles", stalls, exp_stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.MemReqM      = 1'b0;
        bus.MemWriteM    = 1'b0;
        bus.MemSizeM     = 2'b00;
        bus.MemUnsignedM = 1'b0;
        bus.ALUResultM   = 32'h0;
        bus.WriteDataM   = 32'h0;
        #11;
        check("reset_state", {30'h0, debug_state}, 32'h0);
        check("reset_ready", {31'h0, bus.MemReadyM}, 32'h0);
        check("reset_rd", bus.RD, 32'h0);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("idle_rd", bus.RD, 32'h0);
            check("idle_ready", {31'h0, bus.MemReadyM}, 32'h0);
            check("idle_stall", {31'h0, bus.StallM}, 32'h0);
            check("idle_misalign", {31'h0, bus.MisalignM}, 32'h0);
        end

        // Word store/load and lane-level accesses around 0x10.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
        idle(1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        idle(1);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        idle(1);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        idle(1);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        idle(1);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
        idle(1);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        idle(1);
        do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0);
        idle(1);

        // Misaligned word and half, then word still intact.
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        idle(1);
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF);
        idle(1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Back-to-back with MemReqM held high across DONE.
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        idle(2);

        // Reset during the final WAIT cycle aborts the store.
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
        idle(1);
        bus.MemReqM      = 1'b1;
        bus.MemWriteM    = 1'b1;
        bus.MemSizeM     = 2'b10;
        bus.ALUResultM   = 32'h20;
        bus.WriteDataM   = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.MemReqM = 1'b0;
        reset       = 1'b1;
        #1;
        check("abort_state", {30'h0, debug_state}, 32'h0);
        check("abort_ready", {31'h0, bus.MemReadyM}, 32'h0);
        check("abort_rd", bus.RD, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        idle(1);

        // Random traffic over words 0..15 with random upper bits to exercise wrap.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);
        end
        idle(1);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 32'h3F_FFFF) , 10'h0} | 32'($urandom_range(0, 15) * 4)
                | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
